// File: rtl/bin2bcd_scan.sv
// Iterative shift-add-3 binary-to-BCD converter with a start/busy/done handshake,
// a display register and a prescaled multiplexed seven-segment position scanner.
module bin2bcd_scan #(
  parameter int  DATA_W   = 8,
  parameter int  DIGITS   = 4,
  parameter int  SCAN_DIV = 50000,
  localparam int SEL_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              decimal,
  input  logic              display_data,
  input  logic              blank_lz,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [SEL_W-1:0]  select,
  output logic [3:0]        decimal_digit
);

  localparam int INT_DIGITS = DIGITS - 2;
  localparam int BCD_N      = (DATA_W * 301) / 1000 + 1;
  localparam int BCD_W      = 4 * BCD_N;
  localparam int DISP_W     = 4 * INT_DIGITS;
  localparam int PAD_W      = BCD_W + DISP_W;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam int PRE_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [3:0] CODE_C     = 4'd10;
  localparam logic [3:0] CODE_H     = 4'd11;
  localparam logic [3:0] CODE_I     = 4'd12;
  localparam logic [3:0] CODE_BLANK = 4'd13;
  localparam logic [3:0] CODE_DASH  = 4'd14;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [DATA_W-1:0]  sr;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   acc_adj;
  logic [PAD_W-1:0]   acc_pad;
  logic               ovf_next;
  logic [CNT_W-1:0]   cnt;
  logic               dec_l;
  logic [DISP_W-1:0]  disp;
  logic               disp_dec;
  logic [PRE_W-1:0]   pre;
  logic [INT_DIGITS-1:0] zero_from;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < BCD_N; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Zero-extending lets INT_DIGITS exceed BCD_N without out-of-range slices.
  assign acc_pad  = PAD_W'(acc);
  assign ovf_next = |acc_pad[PAD_W-1:DISP_W];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      disp     <= '0;
      disp_dec <= 1'b0;
      acc      <= '0;
      sr       <= '0;
      cnt      <= '0;
      dec_l    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= start;
          if (start) begin
            sr    <= data;
            dec_l <= decimal;
            acc   <= '0;
            cnt   <= CNT_W'(DATA_W);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          {acc, sr} <= {acc_adj[BCD_W-2:0], sr, 1'b0};
          cnt       <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: begin
          disp     <= acc_pad[DISP_W-1:0];
          disp_dec <= dec_l;
          ovf      <= ovf_next;
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre    <= '0;
      select <= '0;
    end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
      pre    <= '0;
      select <= (select == SEL_W'(DIGITS - 1)) ? '0 : select + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // zero_from[k]: nibble k and every nibble above it are zero.
  always_comb begin
    zero_from = '0;
    for (int k = 0; k < INT_DIGITS; k++) begin
      zero_from[k] = ((disp >> (4 * k)) == '0);
    end
  end

  always_comb begin
    decimal_digit = CODE_BLANK;
    if (!reset) begin
      decimal_digit = 4'd0;
    end else if (display_data) begin
      if (select == SEL_W'(2))      decimal_digit = CODE_H;
      else if (select == SEL_W'(1)) decimal_digit = CODE_I;
    end else if (select == '0) begin
      decimal_digit = CODE_C;
    end else if (select == SEL_W'(1)) begin
      decimal_digit = disp_dec ? 4'd5 : 4'd0;
    end else if (ovf) begin
      decimal_digit = CODE_DASH;
    end else begin
      for (int k = 0; k < INT_DIGITS; k++) begin
        if (select == SEL_W'(k + 2)) begin
          decimal_digit = (blank_lz && (k != 0) && zero_from[k]) ? CODE_BLANK : disp[4*k +: 4];
        end
      end
    end
  end

endmodule

// File: tb/tb_bin2bcd_scan.sv
// Directed self-checking bench for bin2bcd_scan: a 4-position/SCAN_DIV=1 instance
// and a 5-position/SCAN_DIV=3 instance share the same stimulus.
module tb_bin2bcd_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = '0;
  logic       decimal = 1'b0;
  logic       display_data = 1'b0;
  logic       blank_lz = 1'b1;

  logic       busy_a, done_a, ovf_a;
  logic [1:0] sel_a;
  logic [3:0] dig_a;
  logic       busy_b, done_b, ovf_b;
  logic [2:0] sel_b;
  logic [3:0] dig_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bin2bcd_scan #(.DATA_W(8), .DIGITS(4), .SCAN_DIV(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .data(data), .decimal(decimal),
    .display_data(display_data), .blank_lz(blank_lz),
    .busy(busy_a), .done(done_a), .ovf(ovf_a), .select(sel_a), .decimal_digit(dig_a)
  );

  bin2bcd_scan #(.DATA_W(8), .DIGITS(5), .SCAN_DIV(3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .data(data), .decimal(decimal),
    .display_data(display_data), .blank_lz(blank_lz),
    .busy(busy_b), .done(done_b), .ovf(ovf_b), .select(sel_b), .decimal_digit(dig_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic read_a(input int pos, output int val);
    val = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (int'(sel_a) == pos) begin
        val = int'(dig_a);
        break;
      end
    end
    if (val < 0) check("read_a timeout", 0, 1);
  endtask

  task automatic read_b(input int pos, output int val);
    val = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (int'(sel_b) == pos) begin
        val = int'(dig_b);
        break;
      end
    end
    if (val < 0) check("read_b timeout", 0, 1);
  endtask

  task automatic expect_a(input string tag, input int e0, input int e1, input int e2, input int e3);
    int v;
    read_a(0, v); check({tag, " pos0"}, v, e0);
    read_a(1, v); check({tag, " pos1"}, v, e1);
    read_a(2, v); check({tag, " pos2"}, v, e2);
    read_a(3, v); check({tag, " pos3"}, v, e3);
  endtask

  task automatic convert(input int d, input bit dec);
    bit seen;
    @(negedge clk);
    data = 8'(d); decimal = dec; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("convert done timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int v, n, pulses;

    // Reset and idle state.
    repeat (3) @(negedge clk);
    check("digit while reset low", int'(dig_a), 0);
    reset = 1'b1;
    #1;
    check("reset busy", int'(busy_a), 0);
    check("reset done", int'(done_a), 0);
    check("reset select", int'(sel_a), 0);
    check("reset ovf", int'(ovf_a), 0);
    expect_a("idle", 10, 0, 0, 13);

    // 37.5: latency and result.
    @(negedge clk);
    data = 8'd37; decimal = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy after start edge", int'(busy_a), 1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_a) begin
        n = i;
        break;
      end
    end
    check("done latency", n, 9);
    check("busy in done cycle", int'(busy_a), 1);
    @(posedge clk); #1;
    check("busy after done", int'(busy_a), 0);
    check("done one cycle", int'(done_a), 0);
    check("ovf 37", int'(ovf_a), 0);
    expect_a("37.5", 10, 5, 7, 3);

    // Overflow and recovery.
    convert(255, 1'b0);
    check("ovf 255", int'(ovf_a), 1);
    expect_a("255", 10, 0, 14, 14);
    read_b(2, v); check("b 255 pos2", v, 5);
    read_b(3, v); check("b 255 pos3", v, 5);
    read_b(4, v); check("b 255 pos4", v, 2);
    check("b ovf 255", int'(ovf_b), 0);
    convert(99, 1'b0);
    check("ovf 99", int'(ovf_a), 0);
    expect_a("99", 10, 0, 9, 9);

    // Hi message and immediate return.
    display_data = 1'b1;
    expect_a("hi", 13, 12, 11, 13);
    v = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sel_a == 2'd2) begin
        v = 0;
        break;
      end
    end
    if (v < 0) check("hi wait timeout", 0, 1);
    #1;
    check("hi pos2 live", int'(dig_a), 11);
    display_data = 1'b0;
    #1;
    check("temp restored live", int'(dig_a), 9);

    // Second start mid-conversion is ignored; data changes do not leak in.
    @(negedge clk);
    data = 8'd37; decimal = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_a) pulses++;
    end
    data = 8'd200; decimal = 1'b1; start = 1'b1;
    @(negedge clk);
    if (done_a) pulses++;
    start = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done_a) pulses++;
    end
    check("single done pulse", pulses, 1);
    expect_a("ignored restart", 10, 0, 7, 3);

    // Reset during SHIFT aborts.
    @(negedge clk);
    data = 8'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy mid shift", int'(busy_a), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("busy after abort", int'(busy_a), 0);
    @(negedge clk);
    reset = 1'b1;
    blank_lz = 1'b0;
    repeat (20) @(negedge clk);
    check("done never after abort", int'(done_a), 0);
    check("ovf after abort", int'(ovf_a), 0);
    expect_a("after abort", 10, 0, 0, 0);
    blank_lz = 1'b1;

    // Scan sequence on the SCAN_DIV=3, DIGITS=5 instance.
    v = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sel_b == 3'd0) begin
        v = 0;
        break;
      end
    end
    if (v < 0) check("scan wait 0 timeout", 0, 1);
    v = -1;
    for (int i = 0; i < 16; i++) begin
      if (sel_b == 3'd1) begin
        v = 0;
        break;
      end
      @(negedge clk);
    end
    if (v < 0) check("scan wait 1 timeout", 0, 1);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("scan step %0d", i), int'(sel_b), ((i / 3) + 1) % 5);
      @(negedge clk);
    end

    // Leading-zero blanking on the 5-position instance.
    convert(7, 1'b0);
    read_b(1, v); check("b 7 pos1", v, 0);
    read_b(2, v); check("b 7 pos2", v, 7);
    read_b(3, v); check("b 7 pos3 blank", v, 13);
    read_b(4, v); check("b 7 pos4 blank", v, 13);
    blank_lz = 1'b0;
    read_b(3, v); check("b 7 pos3 zero", v, 0);
    read_b(4, v); check("b 7 pos4 zero", v, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
